inta_sequencer: RTL and testbench
=================================

# inta_sequencer

Control-side responder of the 8259 PIC core. It consumes the latched request vector from the IRR block, resolves fixed priority against the mask and the in-service register (ISR), and raises the CPU interrupt. It then runs the two-pulse INTA acknowledge cycle: it drives `int_a_counter` and `clear_highest` back into the IRR, sets/clears the ISR and places the 8-bit vector on the data bus during the second INTA.

## Interface
Parameters:
- none (8 request lines, 8086-mode vector format fixed)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `irr`  in  8  request vector from IRR (bit 0 = IR0)
- `mask`  in  8  IMR; 1 = request line masked
- `inta_n`  in  1  CPU acknowledge strobe, active low, already synchronous to `clk`
- `eoi`  in  1  one-cycle pulse: non-specific end of interrupt
- `aeoi`  in  1  auto-EOI mode enable
- `vector_base`  in  5  ICW2 bits T7..T3
- `int_out`  out  1  interrupt request to CPU
- `int_a_counter`  out  2  INTA pulse count to IRR (0 idle, 1 first, 2 second)
- `clear_highest`  out  3  index of the acknowledged request, to IRR
- `clear_valid`  out  1  one-cycle strobe qualifying `clear_highest`
- `isr`  out  8  in-service register
- `data_out`  out  8  vector byte
- `data_oe`  out  1  data bus drive enable

## Operation
- Eligible set: `irr & ~mask`, restricted to bits of strictly higher priority (lower index) than the highest-priority set ISR bit. IR0 has the highest priority. If ISR is empty, all unmasked bits are eligible.
- Edge detect: `inta_q` holds the registered `inta_n` and resets to 1. Fall = `inta_q & ~inta_n`; rise = `~inta_q & inta_n`.
- FSM states: IDLE, REQ, ACK1, ACK2.
- IDLE → REQ when the eligible set is non-zero. `int_out` = 1 from the next edge.
- REQ:
  - If the eligible set goes to zero before a fall, return to IDLE and drop `int_out`.
  - On a fall, resolve the winner from the current eligible set and latch it into `win[2:0]`.
  - If the set is empty in the same cycle as the fall (request withdrawn), use spurious winner 7, set `spur` = 1, and leave ISR unmodified.
  - Otherwise set `isr[win]`.
  - Pulse `clear_valid` with `clear_highest` = `win`, set `int_a_counter` = 1, drop `int_out`, go to ACK1.
- ACK1: ignore the rise. On the next fall, set `int_a_counter` = 2, `data_oe` = 1, `data_out` = {`vector_base`, `win`}, go to ACK2.
- ACK2: hold `data_out`/`data_oe` while `inta_n` is low. On a rise:
  - Set `data_oe` = 0 and `int_a_counter` = 0.
  - If `aeoi` and not `spur`, clear `isr[win]`.
  - Go to IDLE.
- `eoi` (any state): clear the highest-priority set bit of ISR, computed from the pre-edge ISR value.
  - If `eoi` coincides with the ISR set in REQ, both apply: clear from the old ISR, set the new bit. If they target the same bit, the set wins.
  - `eoi` with ISR empty is a no-op.
- `mask` changes during ACK1/ACK2 do not affect `win`.
- Reset (asynchronous, any state) returns to IDLE with every output 0, `inta_q` = 1 and `win` = 0. An in-progress acknowledge is abandoned.

## Timing
- Reset values: `int_out` 0, `int_a_counter` 0, `clear_highest` 0, `clear_valid` 0, `isr` 0x00, `data_out` 0x00, `data_oe` 0.
- Request to `int_out`: 1 cycle (eligible bit seen at edge N → `int_out` high after edge N).
- First `inta_n` low sampled at edge N: fall is detected combinationally at that edge, so `isr`, `clear_valid` and `int_a_counter` = 1 are visible after edge N. `clear_valid` is high for exactly one cycle.
- Second fall at edge M: `data_oe`/`data_out` valid after edge M. They remain valid through the cycle in which the rise is detected and are 0 after that edge.
- Minimum INTA low/high width: 1 cycle each. Back-to-back acknowledge cycles are allowed: a new IDLE → REQ decision happens on the edge after return to IDLE.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, `irr` = 0x04, `mask` = 0, `vector_base` = 0x08, two INTA pulses → `int_out` rises 1 cycle after the request. First fall gives `isr` = 0x04, `clear_highest` = 2 with a 1-cycle `clear_valid`, `int_a_counter` = 1. Second fall gives `data_out` = 0x42 with `data_oe` = 1 and `int_a_counter` = 2. Final rise gives `data_oe` = 0 and counter 0.
- `irr` = 0xFF, `mask` = 0x01 → winner 1 (vector low bits 001), `isr` = 0x02. Then `eoi` → `isr` = 0x00.
- Nesting: with `isr` = 0x10 held, `irr` = 0x20 → `int_out` stays 0. `irr` = 0x08 → `int_out` = 1 and after acknowledge `isr` = 0x18. One `eoi` → 0x10.
- `aeoi` = 1, `irr` = 0x80, full acknowledge → `isr` returns to 0x00 on the final rise. Withdraw `irr` to 0 in the same cycle as the first fall → spurious vector {`vector_base`, 111} and ISR unchanged.
- Assert `reset` while in ACK2 with `data_oe` = 1 → all outputs 0 immediately (asynchronous). Then `irr` = 0x01 re-raises `int_out` in 1 cycle.
- `eoi` coincident with the first fall, `isr` = 0x04, `irr` = 0x02 → `isr` = 0x02 after the edge.

Source files
------------

// File: rtl/inta_sequencer.sv
// inta_sequencer: priority resolution, CPU interrupt request and the
// two-pulse INTA acknowledge cycle for an 8-input 8259-style PIC core.
module inta_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irr,
    input  logic [7:0] mask,
    input  logic       inta_n,
    input  logic       eoi,
    input  logic       aeoi,
    input  logic [4:0] vector_base,
    output logic       int_out,
    output logic [1:0] int_a_counter,
    output logic [2:0] clear_highest,
    output logic       clear_valid,
    output logic [7:0] isr,
    output logic [7:0] data_out,
    output logic       data_oe
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] ACK1 = 2'd2;
    localparam logic [1:0] ACK2 = 2'd3;

    logic [1:0] state;
    logic       inta_q;
    logic [2:0] win;
    logic       spur;

    logic       fall, rise;
    logic [3:0] isr_top;     // index of highest-priority ISR bit, 8 when empty
    logic [7:0] elig;
    logic [2:0] elig_win;
    logic [2:0] fall_win;
    logic [7:0] eoi_clr, aeoi_clr, isr_set, isr_next;

    assign fall = inta_q & ~inta_n;
    assign rise = ~inta_q & inta_n;

    // Highest-priority in-service level and the requests allowed to nest above it
    always_comb begin
        isr_top = 4'd8;
        for (int i = 7; i >= 0; i--)
            if (isr[i]) isr_top = 4'(i);
        elig = 8'h00;
        for (int i = 0; i < 8; i++)
            elig[i] = irr[i] & ~mask[i] & (4'(i) < isr_top);
        elig_win = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (elig[i]) elig_win = 3'(i);
    end

    // Withdrawn request at the first fall yields the spurious level 7
    assign fall_win = (elig == 8'h00) ? 3'd7 : elig_win;

    // ISR update: EOI and auto-EOI clears from the old value, acknowledge set wins
    always_comb begin
        eoi_clr = 8'h00;
        if (eoi && !isr_top[3]) eoi_clr[isr_top[2:0]] = 1'b1;
        aeoi_clr = 8'h00;
        if (state == ACK2 && rise && aeoi && !spur) aeoi_clr[win] = 1'b1;
        isr_set = 8'h00;
        if (state == REQ && fall && elig != 8'h00) isr_set[elig_win] = 1'b1;
        isr_next = (isr & ~eoi_clr & ~aeoi_clr) | isr_set;
    end

    // Acknowledge sequencer and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            inta_q        <= 1'b1;
            win           <= 3'd0;
            spur          <= 1'b0;
            int_out       <= 1'b0;
            int_a_counter <= 2'd0;
            clear_highest <= 3'd0;
            clear_valid   <= 1'b0;
            isr           <= 8'h00;
            data_out      <= 8'h00;
            data_oe       <= 1'b0;
        end else begin
            inta_q      <= inta_n;
            clear_valid <= 1'b0;
            isr         <= isr_next;
            case (state)
                IDLE: begin
                    if (elig != 8'h00) begin
                        state   <= REQ;
                        int_out <= 1'b1;
                    end
                end
                REQ: begin
                    if (fall) begin
                        win           <= fall_win;
                        spur          <= (elig == 8'h00);
                        clear_highest <= fall_win;
                        clear_valid   <= 1'b1;
                        int_a_counter <= 2'd1;
                        int_out       <= 1'b0;
                        state         <= ACK1;
                    end else if (elig == 8'h00) begin
                        int_out <= 1'b0;
                        state   <= IDLE;
                    end
                end
                ACK1: begin
                    if (fall) begin
                        int_a_counter <= 2'd2;
                        data_oe       <= 1'b1;
                        data_out      <= {vector_base, win};
                        state         <= ACK2;
                    end
                end
                ACK2: begin
                    if (rise) begin
                        int_a_counter <= 2'd0;
                        data_oe       <= 1'b0;
                        data_out      <= 8'h00;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inta_sequencer.sv
// Bench for inta_sequencer: directed scenarios plus randomized acknowledge
// cycles, checked against an ISR/priority model built from the rules.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irr, mask;
    logic       inta_n, eoi, aeoi;
    logic [4:0] vector_base;
    logic       int_out;
    logic [1:0] int_a_counter;
    logic [2:0] clear_highest;
    logic       clear_valid;
    logic [7:0] isr, data_out;
    logic       data_oe;

    int tests = 0;
    int fails = 0;
    logic [7:0] m_isr;

    inta_sequencer dut (
        .clk(clk), .reset(reset), .irr(irr), .mask(mask), .inta_n(inta_n),
        .eoi(eoi), .aeoi(aeoi), .vector_base(vector_base), .int_out(int_out),
        .int_a_counter(int_a_counter), .clear_highest(clear_highest),
        .clear_valid(clear_valid), .isr(isr), .data_out(data_out), .data_oe(data_oe)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Lowest set index (highest priority), 8 if none
    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    function automatic logic [7:0] elig_f(input logic [7:0] ir, input logic [7:0] mk,
                                          input logic [7:0] is);
        logic [7:0] e;
        int p;
        p = lowest(is);
        e = ir & ~mk;
        for (int i = 0; i < 8; i++) if (i >= p) e[i] = 1'b0;
        return e;
    endfunction

    function automatic logic [7:0] clear_lowest(input logic [7:0] v);
        int p;
        p = lowest(v);
        if (p < 8) v[p] = 1'b0;
        return v;
    endfunction

    task automatic do_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        m_isr = clear_lowest(m_isr);
        chk("isr_after_eoi", isr, m_isr);
    endtask

    // Full request + two-pulse acknowledge; wd withdraws irr at the first fall,
    // ef pulses eoi coincident with the first fall.
    task automatic do_ack(input logic [7:0] ir, input logic [7:0] mk,
                          input logic ae, input logic wd, input logic ef);
        logic [7:0] e;
        int w;
        logic sp;
        irr = ir; mask = mk; aeoi = ae;
        e = elig_f(ir, mk, m_isr);
        tick();
        chk("int_out_req", int_out, e != 8'h00);
        if (e != 8'h00) begin
            inta_n = 1'b0;
            if (wd) irr = 8'h00;
            if (ef) begin
                eoi = 1'b1;
                m_isr = clear_lowest(m_isr);
            end
            if (wd) begin w = 7; sp = 1'b1; end
            else begin w = lowest(e); sp = 1'b0; m_isr[w] = 1'b1; end
            tick();
            eoi = 1'b0;
            chk("clear_valid_1", clear_valid, 1);
            chk("clear_highest", clear_highest, w);
            chk("counter_1", int_a_counter, 1);
            chk("int_out_ack", int_out, 0);
            chk("isr_ack", isr, m_isr);
            inta_n = 1'b1;
            mask = 8'($urandom);
            tick();
            chk("clear_valid_0", clear_valid, 0);
            chk("counter_1_hold", int_a_counter, 1);
            chk("data_oe_ack1", data_oe, 0);
            inta_n = 1'b0;
            tick();
            chk("data_oe_2", data_oe, 1);
            chk("data_out", data_out, {vector_base, 3'(w)});
            chk("counter_2", int_a_counter, 2);
            if ($urandom_range(1) == 1) begin
                tick();
                chk("data_oe_hold", data_oe, 1);
            end
            inta_n = 1'b1;
            tick();
            if (ae && !sp) m_isr[w] = 1'b0;
            chk("data_oe_end", data_oe, 0);
            chk("counter_end", int_a_counter, 0);
            chk("data_out_end", data_out, 0);
            chk("isr_end", isr, m_isr);
        end
        irr = 8'h00; mask = 8'h00;
    endtask

    initial begin
        reset = 1'b1; irr = 8'h00; mask = 8'h00; inta_n = 1'b1;
        eoi = 1'b0; aeoi = 1'b0; vector_base = 5'h08; m_isr = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_int_out", int_out, 0);
        chk("rst_counter", int_a_counter, 0);
        chk("rst_clear", {clear_valid, clear_highest}, 0);
        chk("rst_isr", isr, 0);
        chk("rst_data", {data_oe, data_out}, 0);
        reset = 1'b0;
        tick();

        // Basic acknowledge of IR2 with base 0x08 -> vector 0x42
        do_ack(8'h04, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("isr_ir2", isr, 8'h04);
        do_eoi();

        // All requests, IR0 masked -> winner 1
        do_ack(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("isr_ir1", isr, 8'h02);
        do_eoi();
        chk("isr_empty", isr, 8'h00);

        // Nesting: lower priority blocked, higher priority nests
        do_ack(8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
        irr = 8'h20;
        tick(); tick();
        chk("nest_blocked", int_out, 0);
        irr = 8'h00;
        tick();
        do_ack(8'h08, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("nest_isr", isr, 8'h18);
        do_eoi();
        chk("nest_eoi", isr, 8'h10);
        do_eoi();
        do_eoi();   // EOI on empty ISR is a no-op

        // Auto-EOI, then spurious acknowledge
        do_ack(8'h80, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("aeoi_isr", isr, 8'h00);
        vector_base = 5'h11;
        do_ack(8'h80, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("spur_isr", isr, 8'h00);
        aeoi = 1'b0;

        // EOI coincident with first fall
        do_ack(8'h04, 8'h00, 1'b0, 1'b0, 1'b0);
        do_ack(8'h02, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("eoi_coincide", isr, 8'h02);
        do_eoi();

        // Asynchronous reset in ACK2
        irr = 8'h04;
        tick();
        inta_n = 1'b0; tick();
        inta_n = 1'b1; tick();
        inta_n = 1'b0; tick();
        chk("pre_rst_oe", data_oe, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_oe", data_oe, 0);
        chk("arst_data", data_out, 0);
        chk("arst_isr", isr, 0);
        chk("arst_cnt", int_a_counter, 0);
        inta_n = 1'b1; irr = 8'h00;
        tick();
        reset = 1'b0; m_isr = 8'h00;
        irr = 8'h01;
        tick();
        chk("reraise", int_out, 1);
        irr = 8'h00;
        tick();
        chk("withdraw_req", int_out, 0);

        // Randomized acknowledge cycles
        for (int n = 0; n < 40; n++) begin
            vector_base = 5'($urandom);
            do_ack(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(5) == 0), 1'b0);
            if (m_isr != 8'h00 && $urandom_range(1) == 1) do_eoi();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
